// File: rtl/id_decode_stage.sv
// RISC-V decode stage: combinational decode of the fetched word feeding a
// registered two-entry (main + skid) output buffer with a valid/ready handshake.
module id_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_instr_i,
  input  logic            if_ex_valid_i,
  input  logic [XLEN-1:0] if_ex_cause_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [6:0]      id_opcode_o,
  output logic [2:0]      id_funct3_o,
  output logic [6:0]      id_funct7_o,
  output logic [4:0]      id_rd_o,
  output logic [4:0]      id_rs1_o,
  output logic [4:0]      id_rs2_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic            id_ex_valid_o,
  output logic [XLEN-1:0] id_ex_cause_o,
  output logic [XLEN-1:0] id_ex_tval_o
);

  typedef enum logic [6:0] {
    OP_LOAD    = 7'h03, OP_LOADFP  = 7'h07, OP_CUSTOM0 = 7'h0B, OP_MISCMEM = 7'h0F,
    OP_OPIMM   = 7'h13, OP_AUIPC   = 7'h17, OP_OPIMM32 = 7'h1B, OP_STORE   = 7'h23,
    OP_STOREFP = 7'h27, OP_CUSTOM1 = 7'h2B, OP_AMO     = 7'h2F, OP_OP      = 7'h33,
    OP_LUI     = 7'h37, OP_OP32    = 7'h3B, OP_MADD    = 7'h43, OP_MSUB    = 7'h47,
    OP_NMSUB   = 7'h4B, OP_NMADD   = 7'h4F, OP_OPFP    = 7'h53, OP_RSRVD1  = 7'h57,
    OP_CUSTOM2 = 7'h5B, OP_BRANCH  = 7'h63, OP_JALR    = 7'h67, OP_RSRVD2  = 7'h6B,
    OP_JAL     = 7'h6F, OP_SYSTEM  = 7'h73, OP_RSRVD3  = 7'h77, OP_CUSTOM3 = 7'h7B
  } opcode_t;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = XLEN'(2);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            ex_valid;
    logic [XLEN-1:0] ex_cause;
    logic [XLEN-1:0] ex_tval;
  } dec_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  opcode_t op;
  dec_t    dec;
  dec_t    main_q, skid_q;
  logic    main_valid_q, skid_valid_q;
  logic    illegal;
  logic    accept;

  assign op = opcode_t'(if_instr_i[6:0]);

  always_comb begin
    dec        = '0;
    illegal    = (if_instr_i[1:0] != 2'b11);
    dec.pc     = if_pc_i;
    dec.opcode = if_instr_i[6:0];
    dec.funct3 = if_instr_i[14:12];
    dec.funct7 = if_instr_i[31:25];
    dec.rd     = if_instr_i[11:7];
    dec.rs1    = if_instr_i[19:15];
    dec.rs2    = if_instr_i[24:20];
    unique case (op)
      OP_LOAD, OP_OPIMM, OP_OPIMM32, OP_JALR, OP_SYSTEM, OP_MISCMEM:
        dec.imm = sext({{20{if_instr_i[31]}}, if_instr_i[31:20]});
      OP_STORE: begin
        dec.imm = sext({{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]});
        dec.rd  = '0;
      end
      OP_BRANCH: begin
        dec.imm = sext({{20{if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                        if_instr_i[11:8], 1'b0});
        dec.rd  = '0;
      end
      OP_LUI, OP_AUIPC:
        dec.imm = sext({if_instr_i[31:12], 12'b0});
      OP_JAL:
        dec.imm = sext({{12{if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                        if_instr_i[30:21], 1'b0});
      default: dec.imm = '0;
    endcase
    unique case (op)
      OP_LOADFP, OP_STOREFP, OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD, OP_OPFP, OP_AMO,
      OP_CUSTOM0, OP_CUSTOM1, OP_CUSTOM2, OP_CUSTOM3, OP_RSRVD1, OP_RSRVD2, OP_RSRVD3:
        illegal = 1'b1;
      OP_OPIMM32, OP_OP32:
        if (XLEN == 32) illegal = 1'b1;
      default: ;
    endcase
    // A fetch-side fault outranks anything decode could report.
    if (if_ex_valid_i) begin
      dec.ex_valid = 1'b1;
      dec.ex_cause = if_ex_cause_i;
      dec.ex_tval  = if_pc_i;
    end else if (illegal) begin
      dec.ex_valid = 1'b1;
      dec.ex_cause = ILLEGAL_INSTR;
      dec.ex_tval  = XLEN'(if_instr_i);
    end
  end

  assign if_ready_o = !skid_valid_q;
  assign accept     = if_valid_i && if_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // Upstream is blocked while full, so only a drain can happen here.
      if (id_ready_i) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && id_ready_i) begin
        main_q <= dec;
      end else if (accept) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end else if (id_ready_i) begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      main_q       <= dec;
      main_valid_q <= 1'b1;
    end
  end

  assign id_valid_o    = main_valid_q;
  assign id_pc_o       = main_q.pc;
  assign id_opcode_o   = main_q.opcode;
  assign id_funct3_o   = main_q.funct3;
  assign id_funct7_o   = main_q.funct7;
  assign id_rd_o       = main_q.rd;
  assign id_rs1_o      = main_q.rs1;
  assign id_rs2_o      = main_q.rs2;
  assign id_imm_o      = main_q.imm;
  assign id_ex_valid_o = main_q.ex_valid;
  assign id_ex_cause_o = main_q.ex_cause;
  assign id_ex_tval_o  = main_q.ex_tval;

endmodule
